// File: rtl/alu_digit_serial.sv
// rtl/alu_digit_serial.sv - digit-serial ALU, one SLICE-bit slice per clock, LSB slice first
module alu_digit_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       sel_r;
  logic             carry;
  logic [IW-1:0]    idx;

  int               shamt;
  logic [WIDTH-1:0] a_sh, b_sh, next_out;
  logic [SLICE-1:0] as, bs, rs;
  logic [SLICE:0]   sum;
  logic             is_add, is_sub, last, a_msb, b_msb, r_msb;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign zero      = ~|out;
  assign negative  = out[WIDTH-1];

  assign is_add = (sel_r == 3'b110);
  assign is_sub = (sel_r == 3'b101);
  assign last   = (idx == IW'(N - 1));
  assign a_msb  = a_r[WIDTH-1];
  assign b_msb  = b_r[WIDTH-1];
  assign r_msb  = rs[SLICE-1];

  // Slice datapath: SUB reuses the adder with inverted B and carry seeded to 1.
  always_comb begin
    shamt = int'(idx) * SLICE;
    a_sh  = a_r >> shamt;
    b_sh  = b_r >> shamt;
    as    = a_sh[SLICE-1:0];
    bs    = b_sh[SLICE-1:0];
    sum   = {1'b0, as} + {1'b0, (is_sub ? ~bs : bs)} + {{SLICE{1'b0}}, carry};
    case (sel_r)
      3'b001:         rs = ~as;
      3'b011:         rs = ~(as & bs);
      3'b100:         rs = ~(as | bs);
      3'b101, 3'b110: rs = sum[SLICE-1:0];
      default:        rs = as;
    endcase
    next_out = (out & ~(SLICE_MASK << shamt)) | (WIDTH'(rs) << shamt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sel_r    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sel_r <= select;
            idx   <= '0;
            carry <= (select == 3'b110) ? c_in : (select == 3'b101);
            state <= RUN;
          end
        end
        RUN: begin
          out   <= next_out;
          carry <= sum[SLICE];
          idx   <= idx + 1'b1;
          if (last) begin
            state    <= DONE;
            c_out    <= (is_add || is_sub) ? sum[SLICE] : 1'b0;
            overflow <= is_add ? ((a_msb == b_msb) && (r_msb != a_msb)) :
                        is_sub ? ((a_msb != b_msb) && (r_msb != a_msb)) : 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// tb/tb_alu_digit_serial.sv - scoreboard bench for alu_digit_serial (WIDTH=16, SLICE=4)
module tb_alu_digit_serial;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, c_in, out_valid, out_ready;
  logic        c_out, zero, negative, overflow, busy;
  logic [15:0] a, b, out;
  logic [2:0]  select;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];

  alu_digit_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .c_out(c_out), .zero(zero),
    .negative(negative), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Result packing: {out, c_out, zero, negative, overflow}
  always @(negedge clk)
    if (!reset && out_valid && out_ready)
      got_q.push_back({out, c_out, zero, negative, overflow});

  function automatic logic [19:0] model(input logic [15:0] ai, input logic [15:0] bi,
                                        input logic [2:0] s, input logic c);
    logic [16:0] r;
    logic [15:0] o;
    logic co, v;
    co = 1'b0;
    v  = 1'b0;
    case (s)
      3'b001: o = ~ai;
      3'b011: o = ~(ai & bi);
      3'b100: o = ~(ai | bi);
      3'b101: begin
        r = {1'b0, ai} + {1'b0, ~bi} + 17'd1;
        o = r[15:0]; co = r[16];
        v = (ai[15] != bi[15]) && (o[15] != ai[15]);
      end
      3'b110: begin
        r = {1'b0, ai} + {1'b0, bi} + {16'd0, c};
        o = r[15:0]; co = r[16];
        v = (ai[15] == bi[15]) && (o[15] != ai[15]);
      end
      default: o = ai;
    endcase
    return {o, co, (o == 16'd0), o[15], v};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] s,
                      input logic c, input bit push, output bit ok);
    a = av; b = bv; select = s; c_in = c; in_valid = 1'b1;
    if (push) exp_q.push_back(model(av, bv, s, c));
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      tick;
    end
    tick;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); select = 3'($urandom); c_in = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick; cyc++; end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++;
    if ({out, c_out, overflow, negative, zero, out_valid, busy, in_ready} !== {16'h0, 7'b0001001}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h",
               {out, c_out, overflow, negative, zero, out_valid, busy, in_ready}, {16'h0, 7'b0001001});
    end
  endtask

  task automatic test_add_wrap;
    bit ok; int cyc; logic [19:0] g, e;
    send(16'hFFFF, 16'h0001, 3'b110, 1'b0, 1'b1, ok);
    wait_done(cyc);
    checks++;
    if (!ok || cyc !== 4) begin failures++; $display("FAIL add_latency got=%0d want=4 accepted=%0d", cyc, ok); end
    checks++;
    if ({out, c_out, zero, overflow} !== {16'h0000, 3'b110}) begin
      failures++; $display("FAIL add_wrap got=%h want=%h", {out, c_out, zero, overflow}, {16'h0000, 3'b110});
    end
    handshake;
    checks++;
    if (got_q.size() == 0) begin failures++; $display("FAIL add_sb got=none want=%h", exp_q[0]); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin failures++; $display("FAIL add_sb got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_sub;
    bit ok; int cyc; logic [19:0] g, e;
    logic [15:0] sa[2] = '{16'h8000, 16'h0001};
    logic [15:0] sb[2] = '{16'h0001, 16'h0002};
    logic [19:0] lit[2] = '{{16'h7FFF, 4'b1001}, {16'hFFFF, 4'b0010}};
    for (int k = 0; k < 2; k++) begin
      send(sa[k], sb[k], 3'b101, 1'b0, 1'b1, ok);
      wait_done(cyc);
      checks++;
      if ({out, c_out, zero, negative, overflow} !== lit[k]) begin
        failures++; $display("FAIL sub_%0d got=%h want=%h", k, {out, c_out, zero, negative, overflow}, lit[k]);
      end
      handshake;
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL sub_sb_%0d got=none want=%h", k, exp_q[0]); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL sub_sb_%0d got=%h want=%h", k, g, e); end
      end
    end
  endtask

  task automatic test_logic;
    bit ok; int cyc; logic [19:0] g, e;
    logic [15:0] la[3]  = '{16'hF0F0, 16'hF0F0, 16'h1234};
    logic [15:0] lb[3]  = '{16'hFF00, 16'hFF00, 16'hA5A5};
    logic [2:0]  ls[3]  = '{3'b011, 3'b100, 3'b111};
    logic [15:0] lit[3] = '{16'h0FFF, 16'h000F, 16'h1234};
    for (int k = 0; k < 3; k++) begin
      send(la[k], lb[k], ls[k], 1'b1, 1'b1, ok);
      wait_done(cyc);
      checks++;
      if ({out, c_out, overflow} !== {lit[k], 2'b00}) begin
        failures++; $display("FAIL logic_%0d got=%h want=%h", k, {out, c_out, overflow}, {lit[k], 2'b00});
      end
      handshake;
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL logic_sb_%0d got=none want=%h", k, exp_q[0]); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL logic_sb_%0d got=%h want=%h", k, g, e); end
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok; int cyc; logic [19:0] snap, g, e;
    send(16'h7FFF, 16'h0001, 3'b110, 1'b0, 1'b1, ok);
    wait_done(cyc);
    snap = {out, c_out, zero, negative, overflow};
    in_valid = 1'b1; a = 16'hBEEF; select = 3'b000; c_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b = 16'($urandom);
      tick;
      checks++;
      if ({out, c_out, zero, negative, overflow, in_ready, out_valid} !== {snap, 2'b01}) begin
        failures++; $display("FAIL hold_%0d got=%h want=%h", k,
                             {out, c_out, zero, negative, overflow, in_ready, out_valid}, {snap, 2'b01});
      end
    end
    handshake;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_handoff got=%b want=1", in_ready); end
    exp_q.push_back(model(16'hBEEF, 16'h0000, 3'b000, 1'b0));
    tick;
    in_valid = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL held_req_latency got=%0d want=4", cyc); end
    handshake;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL bp_sb_%0d got=none want=%h", k, exp_q[0]); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL bp_sb_%0d got=%h want=%h", k, g, e); end
      end
    end
  endtask

  task automatic test_mid_run_reset;
    bit ok; int cyc; bit seen; logic [19:0] g, e;
    send(16'h1111, 16'h2222, 3'b110, 1'b0, 1'b0, ok);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid, out, zero} !== {3'b100, 16'h0, 1'b1}) begin
      failures++; $display("FAIL mid_reset got=%h want=%h", {in_ready, busy, out_valid, out, zero}, {3'b100, 16'h0, 1'b1});
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin tick; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL stale_valid got=1 want=0"); end
    send(16'd3, 16'd4, 3'b110, 1'b1, 1'b1, ok);
    wait_done(cyc);
    checks++;
    if (out !== 16'h0008) begin failures++; $display("FAIL add_after_reset got=%h want=0008", out); end
    handshake;
    checks++;
    if (got_q.size() == 0) begin failures++; $display("FAIL rst_sb got=none want=%h", exp_q[0]); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin failures++; $display("FAIL rst_sb got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    int acc[4]; int t; logic [19:0] g, e;
    logic [2:0] ops[4] = '{3'b110, 3'b101, 3'b011, 3'b000};
    logic [15:0] av, bv;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      av = 16'($urandom); bv = 16'($urandom);
      a = av; b = bv; select = ops[k]; c_in = 1'b1;
      exp_q.push_back(model(av, bv, ops[k], 1'b1));
      t = 0;
      while (!in_ready && t < 40) begin tick; t++; end
      acc[k] = cyc_cnt;
      tick;
    end
    in_valid = 1'b0;
    t = 0;
    while (got_q.size() < 4 && t < 40) begin tick; t++; end
    out_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (acc[k] - acc[k-1] !== 6) begin
        failures++; $display("FAIL b2b_interval_%0d got=%0d want=6", k, acc[k] - acc[k-1]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL b2b_sb_%0d got=none want=%h", k, exp_q[0]); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL b2b_sb_%0d got=%h want=%h", k, g, e); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; select = '0; c_in = 1'b0;
    test_reset;
    test_add_wrap;
    test_sub;
    test_logic;
    test_backpressure;
    test_mid_run_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_digit_serial.md
ALU_DIGIT_SERIAL -- requirements
Module: alu_digit_serial

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 16, operand and result width in bits
- SLICE, 4, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept an operand set
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- select  input  3  opcode
- c_in  input  1  carry-in; used by ADD only
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes the result
- out  output  WIDTH  result
- c_out  output  1  carry flag
- zero  output  1  out == 0
- negative  output  1  out[WIDTH-1]
- overflow  output  1  signed overflow
- busy  output  1  high in RUN

Function
REQ-004 Opcodes SHALL be:
- 000 MOV (out = a)
- 001 NOT (out = ~a)
- 011 NAND (~(a&b))
- 100 NOR (~(a|b))
- 101 SUB (a + ~b + 1)
- 110 ADD (a + b + c_in)
- 010, 111 MOV
REQ-005 The block SHALL use FSM states IDLE, RUN and DONE, with in_ready = (state==IDLE), busy = (state==RUN) and out_valid = (state==DONE).
REQ-006 Accept SHALL occur when in_valid && in_ready at a rising edge; a, b, select and c_in are then captured, the slice index is cleared, the carry is initialised (c_in for ADD, 1 for SUB, 0 otherwise), and the FSM goes IDLE->RUN.
REQ-007 RUN SHALL process one SLICE-bit slice per clock, LSB slice first, writing result bits [i*SLICE +: SLICE] and propagating the carry to the next slice.
REQ-008 After N = WIDTH/SLICE RUN cycles the FSM SHALL go RUN->DONE; out_valid SHALL rise exactly N clocks after the accept edge.
REQ-009 On entering DONE, c_out SHALL hold the final carry for ADD/SUB and 0 for logic ops.
REQ-010 On entering DONE, overflow SHALL be:
- ADD: (a_msb==b_msb) && (out_msb!=a_msb)
- SUB: (a_msb!=b_msb) && (out_msb!=a_msb)
- logic ops: 0
REQ-011 SUB carry convention SHALL be c_out=1 means no borrow.
REQ-012 zero and negative SHALL be computed from the full result and be valid whenever out_valid=1.
REQ-013 DONE SHALL hold out and all flags stable while out_ready=0 (backpressure of any length).
REQ-014 out_valid && out_ready SHALL take DONE->IDLE; in_ready rises on the next cycle. No new accept is possible in the same cycle as the handoff.
REQ-015 Inputs a, b, select and c_in SHALL be ignored outside the accept cycle; changes during RUN/DONE have no effect.
REQ-016 in_valid while not in IDLE SHALL NOT be accepted and SHALL NOT be lost by the block; the producer holds it.
REQ-017 out, c_out, overflow and negative SHALL change only at RUN->DONE, at reset, or on the partial-result writes of REQ-007.

Reset
REQ-018 reset=1 at a rising edge SHALL force IDLE from any state, including mid-RUN or DONE, discarding any partial or pending result.
REQ-019 After reset, outputs SHALL be: out=0, c_out=0, overflow=0, negative=0, zero=1, out_valid=0, busy=0, in_ready=1.
REQ-020 reset SHALL take priority over a simultaneous accept or handoff.

Verification (WIDTH=16, SLICE=4)
REQ-021 The bench SHALL cover:
- ADD 0xFFFF+0x0001, c_in=0 -> out=0x0000, c_out=1, zero=1, overflow=0; out_valid exactly 4 clocks after accept.
- SUB 0x8000-0x0001 -> out=0x7FFF, c_out=1, overflow=1, negative=0; SUB 0x0001-0x0002 -> out=0xFFFF, c_out=0, negative=1.
- NAND a=0xF0F0, b=0xFF00 -> 0x0FFF; NOR same operands -> 0x000F; opcode 111 with a=0x1234 -> 0x1234.
- out_ready held low 5 clocks in DONE -> out and flags stable, in_ready=0, in_valid ignored; one-cycle handshake -> in_ready=1 next clock.
- reset asserted on 2nd RUN cycle -> next cycle IDLE, out=0, zero=1, out_valid never asserts; a following ADD 3+4, c_in=1 -> 0x0008.
- Back-to-back transactions with out_ready tied high -> an accept is possible every N+2 clocks, with results in order.
